// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/done bus between the memory stage and memory
interface mem_stage_if;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  modport master (output mem_en, mem_wr, mem_addr, mem_wdata, input mem_rdata, mem_done);
  modport slave  (input mem_en, mem_wr, mem_addr, mem_wdata, output mem_rdata, mem_done);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-stage controller with variable-latency access, stall and sticky error
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [15:0]        alu_in,
  input  logic [15:0]        srcb_in,
  input  logic               memwrt_in,
  input  logic               regsrc_in,
  input  logic [15:0]        wb_reg_in,
  output logic               stall,
  output logic               valid_out,
  output logic [15:0]        wb_data_out,
  output logic [15:0]        wb_reg_out,
  output logic               err,
  mem_stage_if.master        mem
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;
  state_t        state;
  logic [TW-1:0] timer;
  logic [15:0]   wb_reg_q;
  logic          mop;
  assign mop   = memwrt_in | regsrc_in;
  assign stall = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      wb_reg_q      <= '0;
      valid_out     <= 1'b0;
      wb_data_out   <= '0;
      wb_reg_out    <= '0;
      err           <= 1'b0;
      mem.mem_en    <= 1'b0;
      mem.mem_wr    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      valid_out  <= 1'b0;
      mem.mem_en <= 1'b0;
      case (state)
        IDLE: if (valid_in) begin
          if (!mop) begin
            valid_out   <= 1'b1;
            wb_data_out <= alu_in;
            wb_reg_out  <= wb_reg_in;
          end else if (alu_in[0]) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            state         <= REQ;
            mem.mem_en    <= 1'b1;
            mem.mem_wr    <= memwrt_in;
            mem.mem_addr  <= alu_in;
            mem.mem_wdata <= srcb_in;
            wb_reg_q      <= wb_reg_in;
          end
        end
        REQ: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: if (mem.mem_done) begin
          // a store retires its address; only loads take memory data
          valid_out   <= 1'b1;
          wb_data_out <= mem.mem_wr ? mem.mem_addr : mem.mem_rdata;
          wb_reg_out  <= wb_reg_q;
          state       <= IDLE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state <= ERR;
          err   <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
        default: err <= 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven and directed checks for mem_stage
module tb_mem_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic valid_in = 0, memwrt_in = 0, regsrc_in = 0;
  logic [15:0] alu_in = 0, srcb_in = 0, wb_reg_in = 0;
  logic stall, valid_out, err;
  logic [15:0] wb_data_out, wb_reg_out;
  int total = 0, passed = 0;
  mem_stage_if bus();
  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_in(alu_in), .srcb_in(srcb_in),
    .memwrt_in(memwrt_in), .regsrc_in(regsrc_in), .wb_reg_in(wb_reg_in),
    .stall(stall), .valid_out(valid_out), .wb_data_out(wb_data_out),
    .wb_reg_out(wb_reg_out), .err(err), .mem(bus.master)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v; logic [15:0] a, b; logic w, r; logic [15:0] g;
    logic ev; logic [15:0] ed, er;
  } vec_t;
  vec_t vt[6];
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  task automatic put(input logic v, input logic [15:0] a, input logic [15:0] b,
                     input logic w, input logic r, input logic [15:0] g);
    valid_in = v; alu_in = a; srcb_in = b; memwrt_in = w; regsrc_in = r; wb_reg_in = g;
  endtask
  task automatic zero_chk(input string n);
    chk({n, "_stall"}, 16'(stall), 0);
    chk({n, "_valid"}, 16'(valid_out), 0);
    chk({n, "_data"}, wb_data_out, 0);
    chk({n, "_reg"}, wb_reg_out, 0);
    chk({n, "_en"}, 16'(bus.mem_en), 0);
    chk({n, "_wr"}, 16'(bus.mem_wr), 0);
    chk({n, "_addr"}, bus.mem_addr, 0);
    chk({n, "_wdata"}, bus.mem_wdata, 0);
    chk({n, "_err"}, 16'(err), 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1 zero_chk("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #100000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.mem_done = 0; bus.mem_rdata = 0;
    vt[0] = '{1, 16'h0010, 0, 0, 0, 16'h0001, 1, 16'h0010, 16'h0001};
    vt[1] = '{1, 16'h0020, 0, 0, 0, 16'h0002, 1, 16'h0020, 16'h0002};
    vt[2] = '{1, 16'h0030, 0, 0, 0, 16'h0003, 1, 16'h0030, 16'h0003};
    vt[3] = '{0, 16'h9999, 0, 0, 0, 16'h7777, 0, 16'h0030, 16'h0003};
    vt[4] = '{1, 16'hFFFF, 0, 0, 0, 16'h00FF, 1, 16'hFFFF, 16'h00FF};
    vt[5] = '{1, 16'h8000, 16'hABCD, 0, 0, 16'h1111, 1, 16'h8000, 16'h1111};
    @(negedge clk);
    zero_chk("reset");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put(vt[i].v, vt[i].a, vt[i].b, vt[i].w, vt[i].r, vt[i].g);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 16'(valid_out), 16'(vt[i].ev));
      chk($sformatf("vec%0d_data", i), wb_data_out, vt[i].ed);
      chk($sformatf("vec%0d_reg", i), wb_reg_out, vt[i].er);
      chk($sformatf("vec%0d_stall", i), 16'(stall), 0);
      chk($sformatf("vec%0d_en", i), 16'(bus.mem_en), 0);
    end
    // load, done in third WAIT cycle; a held op sits on the inputs meanwhile
    put(1, 16'h0100, 16'h5555, 0, 1, 16'h00A1);
    @(negedge clk);
    chk("ld_req_stall", 16'(stall), 1);
    chk("ld_req_en", 16'(bus.mem_en), 1);
    chk("ld_req_wr", 16'(bus.mem_wr), 0);
    chk("ld_req_addr", bus.mem_addr, 16'h0100);
    put(1, 16'h0777, 0, 0, 0, 16'h00B2);
    for (int w = 1; w <= 3; w++) begin
      @(negedge clk);
      chk($sformatf("ld_w%0d_stall", w), 16'(stall), 1);
      chk($sformatf("ld_w%0d_en", w), 16'(bus.mem_en), 0);
      chk($sformatf("ld_w%0d_valid", w), 16'(valid_out), 0);
    end
    bus.mem_done = 1; bus.mem_rdata = 16'hBEEF;
    @(negedge clk);
    bus.mem_done = 0;
    chk("ld_valid", 16'(valid_out), 1);
    chk("ld_data", wb_data_out, 16'hBEEF);
    chk("ld_reg", wb_reg_out, 16'h00A1);
    chk("ld_stall", 16'(stall), 0);
    @(negedge clk);
    chk("held_valid", 16'(valid_out), 1);
    chk("held_data", wb_data_out, 16'h0777);
    chk("held_reg", wb_reg_out, 16'h00B2);
    // store with both controls set, zero-wait done
    put(1, 16'h0200, 16'h1234, 1, 1, 16'h00C3);
    @(negedge clk);
    put(0, 0, 0, 0, 0, 0);
    chk("st_en", 16'(bus.mem_en), 1);
    chk("st_wr", 16'(bus.mem_wr), 1);
    chk("st_addr", bus.mem_addr, 16'h0200);
    chk("st_wdata", bus.mem_wdata, 16'h1234);
    @(negedge clk);
    bus.mem_done = 1; bus.mem_rdata = 16'hDEAD;
    chk("st_w1_valid", 16'(valid_out), 0);
    @(negedge clk);
    chk("st_valid", 16'(valid_out), 1);
    chk("st_data", wb_data_out, 16'h0200);
    chk("st_reg", wb_reg_out, 16'h00C3);
    chk("st_addr_hold", bus.mem_addr, 16'h0200);
    chk("st_wdata_hold", bus.mem_wdata, 16'h1234);
    @(negedge clk);
    chk("idle_done_valid", 16'(valid_out), 0);
    chk("idle_done_stall", 16'(stall), 0);
    chk("idle_data_hold", wb_data_out, 16'h0200);
    bus.mem_done = 0;
    // done in the last allowed WAIT cycle
    put(1, 16'h0300, 0, 0, 1, 16'h00D4);
    @(negedge clk);
    put(0, 0, 0, 0, 0, 0);
    for (int w = 1; w <= 16; w++) begin
      @(negedge clk);
      chk($sformatf("to1_w%0d_err", w), 16'(err), 0);
      if (w == 16) begin bus.mem_done = 1; bus.mem_rdata = 16'h5A5A; end
    end
    @(negedge clk);
    bus.mem_done = 0;
    chk("to1_valid", 16'(valid_out), 1);
    chk("to1_data", wb_data_out, 16'h5A5A);
    chk("to1_err", 16'(err), 0);
    chk("to1_stall", 16'(stall), 0);
    // never done: timeout error
    put(1, 16'h0400, 0, 0, 1, 16'h00E5);
    @(negedge clk);
    put(0, 0, 0, 0, 0, 0);
    for (int w = 1; w <= 16; w++) begin
      @(negedge clk);
      chk($sformatf("to2_w%0d_err", w), 16'(err), 0);
    end
    put(1, 16'h0011, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("to2_err%0d", c), 16'(err), 1);
      chk($sformatf("to2_stall%0d", c), 16'(stall), 1);
      chk($sformatf("to2_valid%0d", c), 16'(valid_out), 0);
    end
    put(0, 0, 0, 0, 0, 0);
    do_reset();
    // misaligned load
    put(1, 16'h0101, 0, 0, 1, 16'h00F6);
    @(negedge clk);
    put(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("mis_err%0d", c), 16'(err), 1);
      chk($sformatf("mis_stall%0d", c), 16'(stall), 1);
      chk($sformatf("mis_en%0d", c), 16'(bus.mem_en), 0);
      @(negedge clk);
    end
    do_reset();
    // reset in the middle of an access
    put(1, 16'h0500, 16'h0099, 0, 1, 16'h0017);
    @(negedge clk);
    put(0, 0, 0, 0, 0, 0);
    chk("mid_req_en", 16'(bus.mem_en), 1);
    @(negedge clk);
    do_reset();
    bus.mem_done = 1; bus.mem_rdata = 16'h4444;
    @(negedge clk);
    bus.mem_done = 0;
    chk("mid_late_valid", 16'(valid_out), 0);
    chk("mid_late_stall", 16'(stall), 0);
    put(1, 16'h0042, 0, 0, 0, 16'h0028);
    @(negedge clk);
    put(0, 0, 0, 0, 0, 0);
    chk("mid_next_valid", 16'(valid_out), 1);
    chk("mid_next_data", wb_data_out, 16'h0042);
    chk("mid_next_reg", wb_reg_out, 16'h0028);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
